// File: rtl/image_window_blank.sv
// +----------------------------------------------------------------------------+
// | image_window_blank : raster windowing stage, BLANK/CROP, registered output |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module image_window_blank #(
  parameter int              PIXEL_W     = 8,
  parameter int              CHANNELS    = 1,
  parameter int              H_TOTAL     = 900,
  parameter int              V_TOTAL     = 700,
  parameter int              H_ACTIVE    = 800,
  parameter int              V_ACTIVE    = 600,
  parameter int              CNT_W       = 13,
  parameter logic [PIXEL_W-1:0] BLANK_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*PIXEL_W-1:0]  in_data,
  input  logic                         in_valid,
  input  logic                         in_sof,
  output logic                         in_ready,
  input  logic [CNT_W-1:0]             cfg_x0,
  input  logic [CNT_W-1:0]             cfg_y0,
  input  logic                         cfg_mode,
  output logic [CHANNELS*PIXEL_W-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_active,
  output logic                         out_sof,
  output logic                         out_eol
);

  localparam logic [CNT_W-1:0] C_H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] C_H_ACT_L = CNT_W'(H_ACTIVE - 1);
  localparam logic [CHANNELS*PIXEL_W-1:0] C_BLANK = {CHANNELS{BLANK_VALUE}};

  logic [CNT_W-1:0] r_col, r_row;
  logic [CNT_W-1:0] r_sh_x0, r_sh_y0;
  logic             r_sh_mode;

  logic             w_accept, w_at_origin, w_produce, w_active;
  logic             w_mode;
  logic [CNT_W-1:0] w_pcol, w_prow, w_x0, w_y0, w_dx, w_dy;
  logic [CNT_W-1:0] w_next_col, w_next_row;

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_at_origin = in_sof || (r_col == '0 && r_row == '0);
    w_pcol      = in_sof ? '0 : r_col;
    w_prow      = in_sof ? '0 : r_row;
    // The frame's first beat sees live config; the rest of the frame sees the shadow.
    w_x0        = w_at_origin ? cfg_x0   : r_sh_x0;
    w_y0        = w_at_origin ? cfg_y0   : r_sh_y0;
    w_mode      = w_at_origin ? cfg_mode : r_sh_mode;
    w_dx        = w_pcol - w_x0;
    w_dy        = w_prow - w_y0;
    w_active    = (w_pcol >= w_x0) && (w_dx < C_H_ACT) &&
                  (w_prow >= w_y0) && (w_dy < C_V_ACT);
    w_produce   = w_accept && (!w_mode || w_active);
    if (w_pcol == C_H_LAST) begin
      w_next_col = '0;
      w_next_row = (w_prow == C_V_LAST) ? '0 : w_prow + 1'b1;
    end else begin
      w_next_col = w_pcol + 1'b1;
      w_next_row = w_prow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_sh_x0    <= '0;
      r_sh_y0    <= '0;
      r_sh_mode  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_active <= 1'b0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_col <= w_next_col;
        r_row <= w_next_row;
        if (w_at_origin) begin
          r_sh_x0   <= cfg_x0;
          r_sh_y0   <= cfg_y0;
          r_sh_mode <= cfg_mode;
        end
      end
      if (w_produce) begin
        out_valid  <= 1'b1;
        out_data   <= w_active ? in_data : C_BLANK;
        out_active <= w_active;
        out_sof    <= w_active && (w_pcol == w_x0) && (w_prow == w_y0);
        out_eol    <= w_active && (w_dx == C_H_ACT_L);
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/image_window_blank.md
# image_window_blank

Parametrised raster windowing stage for the feature-detection video path. Tracks raster position of an incoming pixel stream against a programmable total frame size and an active window with runtime origin. In BLANK mode it forwards every beat, replacing out-of-window pixels with a constant. In CROP mode it drops out-of-window beats. A registered valid/ready output stage with frame and line markers feeds the downstream detectors.

## Interface
- PIXEL_W, 8, bits per channel
- CHANNELS, 1, channels packed per beat (channel 0 in LSBs)
- H_TOTAL, 900, beats per line (column counter wraps here)
- V_TOTAL, 700, lines per frame (row counter wraps here)
- H_ACTIVE, 800, window width in beats
- V_ACTIVE, 600, window height in lines
- CNT_W, 13, counter and origin width; must hold H_TOTAL-1 and V_TOTAL-1
- BLANK_VALUE, 0, per-channel value substituted in BLANK mode
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- in_data  in  CHANNELS*PIXEL_W  input pixel
- in_valid  in  1  input beat present
- in_sof  in  1  beat is first of frame; forces position to (0,0)
- in_ready  out  1  input beat accepted when in_valid && in_ready
- cfg_x0  in  CNT_W  window column origin
- cfg_y0  in  CNT_W  window row origin
- cfg_mode  in  1  0 = BLANK, 1 = CROP
- out_data  out  CHANNELS*PIXEL_W  output pixel
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accept
- out_active  out  1  output beat lies inside window
- out_sof  out  1  output beat is window pixel (x0,y0)
- out_eol  out  1  output beat is last window pixel of its row

## Operation
- Position counters col (0..H_TOTAL-1), row (0..V_TOTAL-1). They advance only on accepted input beats; stalls and bubbles never move them.
- Per accepted beat, the beat position p is (0,0) if in_sof=1, otherwise (col,row). After the beat, col = p.col+1. At H_TOTAL-1, col wraps to 0 and row increments. row wraps to 0 after V_TOTAL-1.
- Config shadow: a beat at p=(0,0) is evaluated with live cfg_x0/cfg_y0/cfg_mode, and the shadow registers capture them on that beat. All other beats use the shadow values. Config is therefore frame-atomic; mid-frame cfg changes take effect next frame.
- Window test, using unsigned CNT_W arithmetic with no wrap of the window: active = col>=x0 && col-x0<H_ACTIVE && row>=y0 && row-y0<V_ACTIVE. A window exceeding the totals is clipped at the frame edge.
- BLANK mode: every accepted beat produces one output beat. out_data = in_data if active, otherwise BLANK_VALUE replicated per channel.
- CROP mode: only active beats produce output. Inactive beats are consumed with no output.
- out_sof = active && col==x0 && row==y0. out_eol = active && col-x0==H_ACTIVE-1. Both are 0 on inactive beats.
- Output register: one stage. in_ready = !out_valid || out_ready. When a beat is accepted and produces output, the register loads and out_valid=1. When out_valid && out_ready and no new output loads, out_valid clears. A dropped CROP beat still requires in_ready.

## Timing
- Reset (asynchronous assert, deasserted synchronously by system):
  - counters = 0
  - shadow = 0
  - mode = BLANK
  - out_valid = 0, out_data = 0, out_active = 0, out_sof = 0, out_eol = 0
  - in_ready = 1 on the first cycle after deassert
- Latency: accepted input at edge N appears on outputs after edge N; 1 cycle.
- Throughput: 1 beat/cycle with out_ready held high. out_ready=0 with out_valid=1 holds all outputs stable and deasserts in_ready.
- Simultaneous pop and push: the register reloads on the same edge; no bubble.
- in_sof at any position, including mid-line or mid-frame, resyncs immediately. That beat is treated as (0,0).
- Reset mid-frame discards the held output beat. The next beat is position (0,0) regardless of in_sof.

## Test plan
Use H_TOTAL=6, V_TOTAL=4, H_ACTIVE=3, V_ACTIVE=2, PIXEL_W=8, CHANNELS=1, BLANK_VALUE=0, with in_data equal to a beat index.
- BLANK, x0=1, y0=1, 24 beats with data=1..24, out_ready=1.
  - 24 outputs, 1 cycle latency.
  - Nonzero only at beats 8,9,10,14,15,16.
  - out_sof on beat 8; out_eol on beats 10 and 16.
- CROP, same frame: exactly 6 outputs, 8,9,10,14,15,16, with the same sof/eol. in_ready stays 1 throughout.
- Backpressure: toggle out_ready 1010… during a CROP frame.
  - No beat lost or duplicated.
  - out_data stable while out_valid && !out_ready.
  - in_ready=0 exactly in those cycles.
- Config atomicity: change x0 from 1 to 2 at beat 12 of frame 0.
  - Frame 0 window is unchanged.
  - Frame 1 active columns are 2..4.
- in_sof injected on beat 10: that beat is (0,0), and the following beats are (1,0),(2,0)…, verified via out_sof position with x0=y0=0.
- Async reset asserted mid-frame with out_valid=1: outputs drop to 0 without a clock edge. The next frame starts at (0,0).
